// File: rtl/pong_pkg.sv
// Shared constants for the paddle input path: FSM state encodings and button bit positions.
package pong_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam int BTN_R = 0;
   localparam int BTN_L = 1;

   typedef logic [1:0] btn_pair_t;

   // True when exactly one direction is pressed.
   function automatic logic is_single(input btn_pair_t b);
      return b[BTN_R] ^ b[BTN_L];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, counter-based debounce and a one-cycle press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_stable,
   output logic o_press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = i_btn;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      press_d  = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         // stable_q is necessarily the opposite level here, so this is a 0->1 edge only
         press_d  = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_stable = stable_q;
   assign o_press  = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// Paddle button conditioner: debounced left/right levels, press pulses and a
// hold-to-accelerate FSM that turns frames held into a per-frame step size.
module btn_conditioner
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int ACCEL_FRAMES    = 15,
   parameter int MAX_LEVEL       = 3,
   parameter int BASE_STEP       = 3,
   parameter int STEP_W          = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_btn,
   input  logic              i_ani_stb,
   output logic [1:0]        o_btn_lr,
   output logic [1:0]        o_press,
   output logic [1:0]        o_level,
   output logic [STEP_W-1:0] o_step
);

   localparam int              FR_W    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(ACCEL_FRAMES - 1);
   localparam logic [1:0]      LVL_MAX = 2'(MAX_LEVEL);

   // Constant multiply; folds into shifts/adds.
   function automatic logic [STEP_W-1:0] step_for(input logic [1:0] lvl);
      return STEP_W'(BASE_STEP * (int'(lvl) + 1));
   endfunction

   btn_pair_t stable;
   btn_pair_t press;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_r (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_btn    (i_btn[BTN_R]),
      .o_stable (stable[BTN_R]),
      .o_press  (press[BTN_R])
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_l (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_btn    (i_btn[BTN_L]),
      .o_stable (stable[BTN_L]),
      .o_press  (press[BTN_L])
   );

   logic [0:0]        state_q, state_d;
   btn_pair_t         dir_q, dir_d;
   logic [FR_W-1:0]   frame_q, frame_d;
   logic [1:0]        level_q, level_d;
   logic [STEP_W-1:0] step_q, step_d;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      frame_d = frame_q;
      level_d = level_q;
      case (state_q)
         ST_IDLE: begin
            level_d = '0;
            frame_d = '0;
            if (is_single(stable)) begin
               state_d = ST_HOLD;
               dir_d   = stable;
            end
         end
         ST_HOLD: begin
            // Any pattern change takes priority over a coincident strobe.
            if (!is_single(stable)) begin
               state_d = ST_IDLE;
               level_d = '0;
               frame_d = '0;
            end else if (stable != dir_q) begin
               dir_d   = stable;
               level_d = '0;
               frame_d = '0;
            end else if (i_ani_stb) begin
               if (frame_q == FR_LAST) begin
                  frame_d = '0;
                  level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 2'd1;
               end else begin
                  frame_d = frame_q + FR_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            level_d = '0;
            frame_d = '0;
         end
      endcase
      step_d = step_for(level_d);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         dir_q   <= '0;
         frame_q <= '0;
         level_q <= '0;
         step_q  <= step_for(2'd0);
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         frame_q <= frame_d;
         level_q <= level_d;
         step_q  <= step_d;
      end
   end

   assign o_btn_lr = stable;
   assign o_press  = press;
   assign o_level  = level_q;
   assign o_step   = step_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a short debounce and fast acceleration.
module tb_btn_conditioner;

   localparam int DC = 4;
   localparam int CW = 3;
   localparam int AF = 3;
   localparam int ML = 3;
   localparam int BS = 3;
   localparam int SW = 5;

   localparam int SEL_LR    = 0;
   localparam int SEL_PRESS = 1;
   localparam int SEL_LVL   = 2;
   localparam int SEL_STEP  = 3;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic [1:0]    i_btn;
   logic          i_ani_stb;
   logic [1:0]    o_btn_lr;
   logic [1:0]    o_press;
   logic [1:0]    o_level;
   logic [SW-1:0] o_step;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (CW),
      .ACCEL_FRAMES    (AF),
      .MAX_LEVEL       (ML),
      .BASE_STEP       (BS),
      .STEP_W          (SW)
   ) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_btn     (i_btn),
      .i_ani_stb (i_ani_stb),
      .o_btn_lr  (o_btn_lr),
      .o_press   (o_press),
      .o_level   (o_level),
      .o_step    (o_step)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int    due;
      int    sel;
      int    val;
      string nm;
   } chk_t;

   chk_t chk_q[$];
   int   press_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   errors = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic expect_at(input int dly, input int sel, input int val, input string nm);
      chk_t c;
      c.due = cyc + dly;
      c.sel = sel;
      c.val = val;
      c.nm  = nm;
      chk_q.push_back(c);
   endtask

   task automatic expect_all(input int dly, input int lr, input int lvl, input string nm);
      expect_at(dly, SEL_LR,   lr,            {nm, "_lr"});
      expect_at(dly, SEL_LVL,  lvl,           {nm, "_level"});
      expect_at(dly, SEL_STEP, BS * (lvl + 1), {nm, "_step"});
   endtask

   // Monitor: timed checks fall due at negedges; every press pulse pops the press queue.
   always @(negedge i_clk) begin : monitor
      chk_t c;
      int   act;
      int   pe;
      while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
         c = chk_q.pop_front();
         case (c.sel)
            SEL_LR:    act = int'(o_btn_lr);
            SEL_PRESS: act = int'(o_press);
            SEL_LVL:   act = int'(o_level);
            default:   act = int'(o_step);
         endcase
         vectors++;
         if (act != c.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d", c.nm, act, c.val, cyc);
         end
      end
      if (o_press != 2'b00) begin
         vectors++;
         if (press_q.size() == 0) begin
            errors++;
            $display("FAIL press_unexpected: got %0d, expected no pulse at cycle %0d", o_press, cyc);
         end else begin
            pe = press_q.pop_front();
            if (int'(o_press) != pe) begin
               errors++;
               $display("FAIL press_value: got %0d, expected %0d at cycle %0d", o_press, pe, cyc);
            end
         end
      end
   end

   task automatic strobe_chk(input int lr, input int lvl);
      i_ani_stb = 1'b1;
      expect_all(1, lr, lvl, "strobe");
      @(negedge i_clk);
      i_ani_stb = 1'b0;
      repeat (9) @(negedge i_clk);
   endtask

   // Drive a new raw pattern; debounced levels move 6 negedges later, the FSM one after that.
   task automatic edge_chk(input logic [1:0] btn, input int lr_old, input int lr_new,
                           input int lv_old, input int lv_new, input int press, input int stb_j);
      i_btn = btn;
      for (int j = 0; j < 8; j++) begin
         i_ani_stb = (j == stb_j);
         expect_all(1, (j >= 5) ? lr_new : lr_old, (j >= 6) ? lv_new : lv_old, "edge");
         if (j == 5 && press != 0) press_q.push_back(press);
         @(negedge i_clk);
      end
      i_ani_stb = 1'b0;
   endtask

   initial begin
      int acc_lvl [20];
      int climb [6];
      acc_lvl = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      climb   = '{0, 0, 1, 1, 1, 2};

      i_rst_n   = 1'b0;
      i_btn     = 2'b00;
      i_ani_stb = 1'b0;
      repeat (3) @(negedge i_clk);
      expect_all(1, 0, 0, "reset");
      expect_at(1, SEL_PRESS, 0, "reset_press");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Bounce rejection, then a clean hold on the right button
      for (int k = 0; k < 20; k++) begin
         i_btn = ((k / 2) % 2 == 0) ? 2'b01 : 2'b00;
         expect_at(1, SEL_LR, 0, "bounce_lr");
         @(negedge i_clk);
      end
      i_btn = 2'b01;
      for (int j = 0; j < 8; j++) begin
         expect_at(1, SEL_LR, (j >= 5) ? 1 : 0, "hold_lr");
         if (j == 5) press_q.push_back(1);
         @(negedge i_clk);
      end

      // Acceleration: 20 strobes, saturating at level 3
      for (int k = 0; k < 20; k++) strobe_chk(1, acc_lvl[k]);

      // Reversal to left from level 3, then climb
      edge_chk(2'b10, 1, 2, 3, 0, 2, -1);
      for (int k = 0; k < 6; k++) strobe_chk(2, climb[k]);

      // Back to right and climb to level 2, then add left
      edge_chk(2'b01, 2, 1, 2, 0, 1, -1);
      for (int k = 0; k < 6; k++) strobe_chk(1, climb[k]);
      edge_chk(2'b11, 1, 3, 2, 0, 2, -1);
      for (int k = 0; k < 3; k++) strobe_chk(3, 0);

      // Strobe colliding with the pattern change must not count
      edge_chk(2'b01, 3, 1, 0, 0, 0, 6);
      strobe_chk(1, 0);
      strobe_chk(1, 0);
      strobe_chk(1, 1);

      // Asynchronous reset mid-HOLD, checked before any further clock edge
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      expect_all(0, 0, 0, "midrst");
      expect_at(0, SEL_PRESS, 0, "midrst_press");
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      for (int j = 0; j < 8; j++) begin
         expect_all(1, (j >= 5) ? 1 : 0, 0, "redebounce");
         if (j == 5) press_q.push_back(1);
         @(negedge i_clk);
      end

      repeat (3) @(negedge i_clk);
      vectors++;
      if (press_q.size() != 0 || chk_q.size() != 0) begin
         errors++;
         $display("FAIL pending: got %0d press and %0d timed entries left, expected 0",
                  press_q.size(), chk_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
